sd_xfer_sequencer: RTL
======================

# sd_xfer_sequencer

Parametrised DMA transfer sequencer for the SD host data path. It latches a transfer request, decodes the transfer type (single / infinite / multiple / stop-multiple) and runs the block-by-block sequence. It issues one `blk_start` per block, counts completed blocks and requests the CMD12 stop command when the transfer ends. It sits between the host register file (mode, block count, start) and the DMA/data-line engine (per-block handshake).

## Interface
- `BLK_CNT_W`, default 16: width of the block count, remaining-block count and completed-block count.
- `CLK`  input  1  single clock; all state updates on rising edge.
- `RESET_L`  input  1  asynchronous, active-low reset.
- `start`  input  1  one-cycle request; sampled only in IDLE.
- `mode`  input  2  transfer mode, bit1 = multi-block select, bit0 = block-count enable; sampled with `start`.
- `block_count`  input  BLK_CNT_W  number of blocks; sampled with `start`.
- `blk_done`  input  1  one-cycle pulse from the data engine at the end of each block.
- `stop_req`  input  1  host abort request, level or pulse.
- `stop_ack`  input  1  command path has issued CMD12.
- `transfer_type`  output  2  00 single, 01 infinite, 10 multiple, 11 stop-multiple.
- `busy`  output  1  high from start acceptance until done.
- `blk_start`  output  1  one-cycle pulse per block to start.
- `blocks_left`  output  BLK_CNT_W  remaining blocks (multiple mode).
- `xfer_count`  output  BLK_CNT_W  completed blocks this transfer.
- `stop_cmd`  output  1  CMD12 request, held until `stop_ack`.
- `done`  output  1  one-cycle completion pulse.

## Operation
- Type decode at start:
  - `mode` 00 and 01 decode to single (00).
  - `mode` 10 decodes to infinite (01).
  - `mode` 11 with `block_count`≠0 decodes to multiple (10).
  - `mode` 11 with `block_count`=0 decodes to stop-multiple (11).
  - The decoded type is registered and `transfer_type` holds it until the next accepted start.
- States: IDLE, XFER, STOP, DONE.
- IDLE:
  - On `start`, latch the type, set `blocks_left`←`block_count` and `xfer_count`←0, and clear the stop latch.
  - Stop-multiple goes to STOP with no `blk_start`.
  - All other types go to XFER and pulse `blk_start`.
- XFER, on `blk_done`:
  - `xfer_count` increments and wraps modulo 2^BLK_CNT_W.
  - Single goes to DONE.
  - Multiple decrements `blocks_left`. If the result is 0, go to STOP. Otherwise stay in XFER and pulse `blk_start`.
  - Infinite never decrements `blocks_left`. If the stop latch is set, go to STOP. Otherwise stay in XFER and pulse `blk_start`.
- Stop latch:
  - `stop_req` high in XFER sets the latch; it is honoured at the next `blk_done` boundary. A block in flight is never cut.
  - In multiple mode, a set latch forces STOP at that boundary even if `blocks_left`≠0.
  - In single mode, `stop_req` is ignored; the transfer ends in DONE with no CMD12.
- STOP: `stop_cmd` is high throughout. On `stop_ack`, go to DONE.
- DONE: lasts one cycle, then returns to IDLE.
- Ignored inputs:
  - `start` outside IDLE.
  - `blk_done` outside XFER.
  - `stop_ack` outside STOP.
  - `stop_req` in IDLE, STOP and DONE.

## Timing
- Reset values, applied asynchronously while `RESET_L`=0:
  - State IDLE.
  - `transfer_type`=00.
  - `busy`, `blk_start`, `stop_cmd`, `done` = 0.
  - `blocks_left`=0, `xfer_count`=0, stop latch clear.
- Reset mid-operation aborts immediately with the same values. `stop_cmd` drops without waiting for `stop_ack`.
- `start` sampled at edge k:
  - `busy`=1 and `transfer_type` are valid after edge k.
  - `blk_start`=1 for exactly the cycle after edge k.
- `blk_done` sampled at edge j with more blocks pending:
  - `blk_start`=1 in the cycle after edge j, giving back-to-back blocks with zero idle cycles.
  - `xfer_count` and `blocks_left` are updated after edge j.
- Simultaneous `stop_req` and `blk_done` at the same edge: the stop takes effect at that boundary, with no further `blk_start`.
- Entry to STOP at edge j: `stop_cmd`=1 after edge j.
  - `stop_ack` sampled at edge m: `stop_cmd`=0 after edge m, and `done` is high in cycle m+1.
  - If `stop_ack` is already high on entry, it is sampled at the first edge in STOP, so `stop_cmd` is high for exactly one cycle.
- DONE: `done`=1 and `busy`=1 for that cycle. `busy` falls and `done` falls together at the next edge (IDLE).
- The earliest next `start` is accepted in the IDLE cycle following DONE.
- `xfer_count` and `blocks_left` hold their final values in IDLE until the next start.

## Test plan
- Single transfer: `mode`=01, `block_count`=5, start.
  - Response: `transfer_type`=00, one `blk_start`.
  - After `blk_done`: `xfer_count`=1, `done` pulse, `stop_cmd` never asserted.
- Multiple transfer: `mode`=11, `block_count`=3, `blk_done` returned 4 cycles after each `blk_start`.
  - Response: `transfer_type`=10, exactly 3 `blk_start` pulses, `blocks_left` 3→2→1→0.
  - `stop_cmd` after the third `blk_done`; `stop_ack` 2 cycles later leads to `done`; `xfer_count`=3.
- Stop-multiple: `mode`=11, `block_count`=0.
  - Response: `transfer_type`=11, no `blk_start`, `stop_cmd` in the cycle after start.
  - `stop_ack` leads to `done`; `xfer_count`=0.
- Infinite with abort: `mode`=10, 6 blocks, then `stop_req` pulse mid-block 7.
  - Response: `transfer_type`=01.
  - The 7th `blk_done` produces no `blk_start` and `stop_cmd`=1; `xfer_count`=7.
- Edge cases: BLK_CNT_W=4, infinite mode run for 17 blocks.
  - `xfer_count` wraps 15→0→1.
  - `start` asserted while busy is ignored.
  - `stop_req` and `blk_done` on the same edge stop immediately.
- Reset: assert `RESET_L`=0 mid-XFER and again while `stop_cmd`=1.
  - Every output goes to its reset value without waiting for a clock edge.
  - A fresh start after release works normally.

Source files
------------

// File: rtl/sd_xfer_sequencer_if.sv
// Host-register and data-engine handshake bundle for the SD transfer sequencer.
// The slave modport is the sequencer side; the master modport is the host/engine side.
interface sd_xfer_sequencer_if #(
    parameter int BLK_CNT_W = 16
);
    logic                 start;
    logic [1:0]           mode;
    logic [BLK_CNT_W-1:0] block_count;
    logic                 blk_done;
    logic                 stop_req;
    logic                 stop_ack;
    logic [1:0]           transfer_type;
    logic                 busy;
    logic                 blk_start;
    logic [BLK_CNT_W-1:0] blocks_left;
    logic [BLK_CNT_W-1:0] xfer_count;
    logic                 stop_cmd;
    logic                 done;

    modport slave (
        input  start, mode, block_count, blk_done, stop_req, stop_ack,
        output transfer_type, busy, blk_start, blocks_left, xfer_count, stop_cmd, done
    );

    modport master (
        output start, mode, block_count, blk_done, stop_req, stop_ack,
        input  transfer_type, busy, blk_start, blocks_left, xfer_count, stop_cmd, done
    );
endinterface

// File: rtl/sd_xfer_sequencer.sv
// SD DMA transfer sequencer: decodes the transfer type at start, issues one blk_start per
// block, counts completed blocks and requests CMD12 when a multi-block transfer ends.
module sd_xfer_sequencer #(
    parameter int BLK_CNT_W = 16
) (
    input  logic                  CLK,
    input  logic                  RESET_L,
    sd_xfer_sequencer_if.slave    bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_STOP = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [1:0] TT_SINGLE = 2'b00;
    localparam logic [1:0] TT_INF    = 2'b01;
    localparam logic [1:0] TT_MULTI  = 2'b10;
    localparam logic [1:0] TT_STOPM  = 2'b11;

    localparam logic [BLK_CNT_W-1:0] CNT_ZERO = {BLK_CNT_W{1'b0}};
    localparam logic [BLK_CNT_W-1:0] CNT_ONE  = {{(BLK_CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]           state_r, state_s;
    logic [1:0]           type_r, type_s;
    logic [BLK_CNT_W-1:0] blocks_left_r, blocks_left_s;
    logic [BLK_CNT_W-1:0] xfer_count_r, xfer_count_s;
    logic                 stop_latch_r, stop_latch_s;
    logic                 stop_seen_s;
    logic                 blk_start_r, blk_start_s;
    logic                 busy_r, stop_cmd_r, done_r;

    // mode bit1 selects multi-block, bit0 enables the count; a zero count means stop only.
    function automatic logic [1:0] decode_type(input logic [1:0] mode, input logic cnt_zero);
        logic [1:0] t;
        case (mode)
            2'b10:   t = TT_INF;
            2'b11:   t = cnt_zero ? TT_STOPM : TT_MULTI;
            default: t = TT_SINGLE;
        endcase
        return t;
    endfunction

    // Next-state and datapath decisions for the block sequence.
    always_comb begin
        state_s       = state_r;
        type_s        = type_r;
        blocks_left_s = blocks_left_r;
        xfer_count_s  = xfer_count_r;
        stop_latch_s  = stop_latch_r;
        blk_start_s   = 1'b0;
        stop_seen_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    type_s        = decode_type(bus.mode, bus.block_count == CNT_ZERO);
                    blocks_left_s = bus.block_count;
                    xfer_count_s  = CNT_ZERO;
                    stop_latch_s  = 1'b0;
                    if (type_s == TT_STOPM) begin
                        state_s = ST_STOP;
                    end else begin
                        state_s     = ST_XFER;
                        blk_start_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_XFER: begin
                // A stop arriving on the same edge as blk_done still ends the transfer there.
                stop_seen_s = (stop_latch_r | bus.stop_req) & (type_r != TT_SINGLE);
                stop_latch_s = stop_seen_s;
                if (bus.blk_done) begin
                    xfer_count_s = xfer_count_r + CNT_ONE;
                    case (type_r)
                        TT_SINGLE: begin
                            state_s = ST_DONE;
                        end
                        TT_MULTI: begin
                            blocks_left_s = blocks_left_r - CNT_ONE;
                            if ((blocks_left_s == CNT_ZERO) || stop_seen_s) begin
                                state_s = ST_STOP;
                            end else begin
                                blk_start_s = 1'b1;
                            end
                        end
                        TT_INF: begin
                            if (stop_seen_s) begin
                                state_s = ST_STOP;
                            end else begin
                                blk_start_s = 1'b1;
                            end
                        end
                        default: begin
                            state_s = ST_STOP;
                        end
                    endcase
                end else begin
                    state_s = ST_XFER;
                end
            end
            ST_STOP: begin
                if (bus.stop_ack) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_STOP;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; status flags are derived from the next state.
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state_r       <= ST_IDLE;
            type_r        <= TT_SINGLE;
            blocks_left_r <= CNT_ZERO;
            xfer_count_r  <= CNT_ZERO;
            stop_latch_r  <= 1'b0;
            blk_start_r   <= 1'b0;
            busy_r        <= 1'b0;
            stop_cmd_r    <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            type_r        <= type_s;
            blocks_left_r <= blocks_left_s;
            xfer_count_r  <= xfer_count_s;
            stop_latch_r  <= stop_latch_s;
            blk_start_r   <= blk_start_s;
            busy_r        <= (state_s != ST_IDLE);
            stop_cmd_r    <= (state_s == ST_STOP);
            done_r        <= (state_s == ST_DONE);
        end
    end

    assign bus.transfer_type = type_r;
    assign bus.busy          = busy_r;
    assign bus.blk_start     = blk_start_r;
    assign bus.blocks_left   = blocks_left_r;
    assign bus.xfer_count    = xfer_count_r;
    assign bus.stop_cmd      = stop_cmd_r;
    assign bus.done          = done_r;

endmodule
